// File: rtl/pwm_pkg.sv
// Shared types and sizing helpers for the multi-channel PWM array.
package pwm_pkg;

  typedef enum logic {PWM_EDGE = 1'b0, PWM_CENTER = 1'b1} pwm_mode_e;
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} pwm_dir_e;

  function automatic int cnt_max(input int dwidth);
    return (32'sd1 <<< dwidth) - 32'sd1;
  endfunction

  // Width of an index over n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: compare the shared counter against this channel's active
// duty, apply the idle-level inversion and register the result.
module pwm_channel #(
  parameter int   DWIDTH = 8,
  parameter logic INV    = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              run_i,
  input  logic [DWIDTH-1:0] cnt_i,
  input  logic [DWIDTH-1:0] duty_i,
  output logic              out_o
);

  logic out_d;
  logic out_q;

  always_comb begin
    out_d = (run_i && (cnt_i < duty_i)) ^ INV;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q <= INV;
    end else begin
      out_q <= out_d;
    end
  end

  assign out_o = out_q;

endmodule

// File: rtl/pwm_array.sv
// Multi-channel PWM generator: prescaled shared counter (edge or center
// aligned), serial duty loader into a shadow bank, commit at period boundaries.
module pwm_array
  import pwm_pkg::*;
#(
  parameter int                  DWIDTH   = 8,
  parameter int                  CHANNELS = 8,
  parameter int                  PRESC    = 1,
  parameter logic [CHANNELS-1:0] INVERT   = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                mode_i,
  input  logic                in_valid_i,
  input  logic [DWIDTH-1:0]   in_data_i,
  output logic                in_ready_o,
  output logic                period_start_o,
  output logic                frame_commit_o,
  output logic [CHANNELS-1:0] out_o
);

  localparam int                SW         = idx_width(CHANNELS);
  localparam int                PW         = idx_width(PRESC);
  localparam logic [DWIDTH-1:0] CNT_MAX    = DWIDTH'(cnt_max(DWIDTH));
  localparam logic [PW-1:0]     PRESC_LAST = PW'(PRESC - 1);
  localparam logic [SW-1:0]     SLOT_LAST  = SW'(CHANNELS - 1);

  logic [PW-1:0]     presc_q, presc_d;
  logic [DWIDTH-1:0] cnt_q, cnt_d;
  pwm_dir_e          dir_q, dir_d;
  pwm_mode_e         mode_q, mode_d;
  logic              restart_q, restart_d;
  logic              tick;
  logic              boundary;
  logic              run;

  logic [SW-1:0]                  slot_q, slot_d;
  logic                           pending_q, pending_d;
  logic [CHANNELS-1:0][DWIDTH-1:0] shadow_q, shadow_d;
  logic [CHANNELS-1:0][DWIDTH-1:0] active_q, active_d;
  logic                           accept;
  logic                           commit;
  logic                           pstart_q;
  logic                           commit_q;

  assign tick = en_i && (presc_q == PRESC_LAST);
  // restart_q marks a counter parked at 0 (after reset or en=0): its next
  // tick opens a new period instead of advancing, so pending frames commit.
  assign run  = en_i && !restart_q;

  always_comb begin
    presc_d   = presc_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    mode_d    = mode_q;
    restart_d = restart_q;
    boundary  = 1'b0;
    if (!en_i) begin
      presc_d   = '0;
      cnt_d     = '0;
      dir_d     = DIR_UP;
      restart_d = 1'b1;
    end else begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        restart_d = 1'b0;
        if (restart_q) begin
          boundary = 1'b1;
        end else begin
          case (dir_q)
            DIR_UP: begin
              if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + DWIDTH'(1);
              end else if (mode_q == PWM_CENTER) begin
                dir_d = DIR_DOWN;
                cnt_d = CNT_MAX - DWIDTH'(1);
              end else begin
                boundary = 1'b1;
              end
            end
            DIR_DOWN: begin
              if (cnt_q <= DWIDTH'(1)) begin
                boundary = 1'b1;
              end else begin
                cnt_d = cnt_q - DWIDTH'(1);
              end
            end
          endcase
        end
        if (boundary) begin
          cnt_d  = '0;
          dir_d  = DIR_UP;
          mode_d = pwm_mode_e'(mode_i);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_q   <= '0;
      cnt_q     <= '0;
      dir_q     <= DIR_UP;
      mode_q    <= PWM_EDGE;
      restart_q <= 1'b1;
    end else begin
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      mode_q    <= mode_d;
      restart_q <= restart_d;
    end
  end

  assign accept = in_valid_i && !pending_q;
  assign commit = boundary && pending_q;

  always_comb begin
    slot_d    = slot_q;
    pending_d = pending_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    if (accept) begin
      shadow_d[slot_q] = in_data_i;
      if (slot_q == SLOT_LAST) begin
        slot_d    = '0;
        pending_d = 1'b1;
      end else begin
        slot_d = slot_q + SW'(1);
      end
    end
    if (commit) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_q    <= '0;
      pending_q <= 1'b0;
      shadow_q  <= '0;
      active_q  <= '0;
      pstart_q  <= 1'b0;
      commit_q  <= 1'b0;
    end else begin
      slot_q    <= slot_d;
      pending_q <= pending_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pstart_q  <= boundary;
      commit_q  <= commit;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    pwm_channel #(
      .DWIDTH (DWIDTH),
      .INV    (INVERT[i])
    ) u_chan (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .run_i  (run),
      .cnt_i  (cnt_q),
      .duty_i (active_q[i]),
      .out_o  (out_o[i])
    );
  end

  assign in_ready_o     = !pending_q;
  assign period_start_o = pstart_q;
  assign frame_commit_o = commit_q;

endmodule
